// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment driver: scans DIGITS patterns onto one segment bus with blanking, PWM and polarity.
// Outputs are registered from the post-edge scan state; inputs are sampled only at slot boundaries.
module seven_seg_scan #(
    parameter int DIGITS      = 4,
    parameter int FREQ        = 2500,
    parameter int CBITS       = 12,
    parameter int BRIGHT_BITS = 4,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7*DIGITS-1:0]    digits_in,
    input  logic [DIGITS-1:0]      blank,
    input  logic [BRIGHT_BITS-1:0] brightness,
    output logic [6:0]             segment,
    output logic [DIGITS-1:0]      digit_sel,
    output logic                   frame_start
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = CBITS + BRIGHT_BITS;
    localparam logic [CBITS-1:0]  FREQ_C  = CBITS'(FREQ);
    localparam logic [PW-1:0]     STEP_C  = PW'((FREQ + 1) >> BRIGHT_BITS);
    localparam logic [IW-1:0]     LAST    = IW'(DIGITS - 1);
    localparam logic [6:0]        SEG_POL = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [DIGITS-1:0] SEL_POL = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [CBITS-1:0]       cnt, cnt_n;
    logic [IW-1:0]          idx, idx_n;
    logic [6:0]             seg_l, seg_n, seg_pick;
    logic                   blank_l, blank_n, blank_pick;
    logic [BRIGHT_BITS-1:0] bright_l, bright_n;
    logic                   wrap;
    logic [PW-1:0]          on_cycles;
    logic                   lit;
    logic [DIGITS-1:0]      sel_n;

    // Everything below is the post-edge view, so outputs line up with cnt/idx.
    always_comb begin
        wrap       = (cnt >= FREQ_C);
        cnt_n      = wrap ? '0 : cnt + CBITS'(1);
        idx_n      = idx;
        if (wrap) begin
            idx_n = (idx == LAST) ? '0 : idx + IW'(1);
        end
        seg_pick   = '0;
        blank_pick = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_n == IW'(k)) begin
                seg_pick   = digits_in[7*k +: 7];
                blank_pick = blank[k];
            end
        end
        seg_n      = wrap ? seg_pick   : seg_l;
        blank_n    = wrap ? blank_pick : blank_l;
        bright_n   = wrap ? brightness : bright_l;
        on_cycles  = PW'(bright_n) * STEP_C;
        lit        = !blank_n && ((&bright_n) || (PW'(cnt_n) < on_cycles));
        sel_n      = '0;
        for (int k = 0; k < DIGITS; k++) begin
            sel_n[k] = lit && (idx_n == IW'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt         <= '0;
            idx         <= LAST;
            seg_l       <= '0;
            blank_l     <= 1'b1;
            bright_l    <= '0;
            frame_start <= 1'b0;
            segment     <= SEG_POL;
            digit_sel   <= SEL_POL;
        end else begin
            cnt         <= cnt_n;
            idx         <= idx_n;
            seg_l       <= seg_n;
            blank_l     <= blank_n;
            bright_l    <= bright_n;
            frame_start <= wrap && (idx_n == '0);
            segment     <= (lit ? seg_n : 7'h00) ^ SEG_POL;
            digit_sel   <= sel_n ^ SEL_POL;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: both polarities driven in parallel, checked every cycle against a slot/time model.
module tb_seven_seg_scan;

    localparam int D  = 3;
    localparam int SL = 8;      // slot length FREQ+1
    localparam int ST = 2;      // PWM step

    logic          clk = 1'b0;
    logic          rst;
    logic [20:0]   digits_in;
    logic [2:0]    blank;
    logic [1:0]    brightness;
    logic [6:0]    seg_h, seg_l;
    logic [2:0]    sel_h, sel_l;
    logic          fs_h, fs_l;

    int vectors = 0;
    int errors  = 0;

    // model state: edges since last reset edge, and values latched at the latest slot start
    int         k = 0;
    int         m_digit = 0;
    logic [6:0] m_seg = '0;
    logic       m_blank = 1'b1;
    logic [1:0] m_bright = '0;

    always #5 clk = ~clk;

    seven_seg_scan #(.DIGITS(3), .FREQ(7), .CBITS(3), .BRIGHT_BITS(2), .ACTIVE_LOW(0)) u_dut_h (
        .clk(clk), .rst(rst), .digits_in(digits_in), .blank(blank), .brightness(brightness),
        .segment(seg_h), .digit_sel(sel_h), .frame_start(fs_h));

    seven_seg_scan #(.DIGITS(3), .FREQ(7), .CBITS(3), .BRIGHT_BITS(2), .ACTIVE_LOW(1)) u_dut_l (
        .clk(clk), .rst(rst), .digits_in(digits_in), .blank(blank), .brightness(brightness),
        .segment(seg_l), .digit_sel(sel_l), .frame_start(fs_l));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic tick();
        logic       lit;
        logic [6:0] e_seg, e_seg_n;
        logic [2:0] e_sel, e_sel_n;
        logic       e_fs;
        @(posedge clk);
        if (!rst) begin
            k = 0;
        end else begin
            k++;
            if (k % SL == 0) begin
                m_digit  = (k / SL - 1) % D;
                m_seg    = digits_in[7*m_digit +: 7];
                m_blank  = blank[m_digit];
                m_bright = brightness;
            end
        end
        lit     = (k >= SL) && !m_blank && (m_bright == 2'd3 || (k % SL) < int'(m_bright) * ST);
        e_seg   = lit ? m_seg : 7'h00;
        e_sel   = lit ? 3'(1 << m_digit) : 3'b000;
        e_fs    = (k >= SL) && (k % SL == 0) && (m_digit == 0);
        e_seg_n = ~e_seg;
        e_sel_n = ~e_sel;
        #1;
        check("segment",      seg_h, e_seg);
        check("digit_sel",    sel_h, e_sel);
        check("frame_start",  fs_h,  e_fs);
        check("segment_al",   seg_l, e_seg_n);
        check("digit_sel_al", sel_l, e_sel_n);
        check("frame_al",     fs_l,  e_fs);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bit found;
        rst        = 1'b0;
        digits_in  = {7'h06, 7'h5B, 7'h3F};
        blank      = 3'b000;
        brightness = 2'd3;

        // reset and first slot, then scan order
        tick();
        tick();
        check("rst_seg_al", seg_l, 7'h7F);
        check("rst_sel_al", sel_l, 3'b111);
        rst = 1'b1;
        run(8);
        check("first_sel", sel_h, 3'b001);
        check("first_seg", seg_h, 7'h3F);
        check("first_fs",  fs_h,  1'b1);
        check("first_sel_al", sel_l, 3'b110);
        check("first_seg_al", seg_l, 7'h40);
        run(8);
        check("slot2_seg", seg_h, 7'h5B);
        run(8);
        check("slot3_sel", sel_h, 3'b100);
        run(30);

        // PWM levels
        brightness = 2'd1;
        run(48);
        brightness = 2'd0;
        run(24);
        brightness = 2'd2;
        run(24);

        // blanking and mid-slot input change
        brightness = 2'd3;
        blank      = 3'b010;
        for (int i = 0; i < 48; i++) begin
            if (i == 3) digits_in[6:0] = 7'($urandom);
            tick();
        end
        blank = 3'b000;

        // reset at cnt=4 of the digit-1 slot
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (k >= SL && m_digit == 1 && k % SL == 4) found = 1'b1;
        end
        check("found_mid_slot", {31'd0, found}, 32'd1);
        rst = 1'b0;
        tick();
        check("midrst_sel", sel_h, 3'b000);
        check("midrst_fs",  fs_h,  1'b0);
        rst = 1'b1;
        run(30);

        // randomized operation with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) digits_in  = 21'($urandom);
            if ($urandom_range(0, 19) == 0) blank      = 3'($urandom);
            if ($urandom_range(0, 19) == 0) brightness = 2'($urandom);
            rst = ($urandom_range(0, 149) != 0);
            tick();
        end
        rst = 1'b1;
        run(24);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised multiplexed seven-segment display driver. It time-multiplexes `DIGITS` 7-bit segment patterns onto one shared segment bus and drives a one-hot digit-select output. Per-digit blanking, PWM brightness control and selectable output polarity are built in. It sits between the display-formatting logic and the board pins, and replaces the fixed two-digit scanner.

## Interface
- `DIGITS`, 4: number of multiplexed digits; must be ≥ 2.
- `FREQ`, 2500: slot length minus one, so each digit is shown for FREQ+1 clocks; must be < 2^CBITS.
- `CBITS`, 12: width of the slot counter.
- `BRIGHT_BITS`, 4: width of the brightness input.
- `ACTIVE_LOW`, 0: when 1, `segment` and `digit_sel` are driven inverted (common-anode boards).
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset).
- `digits_in`  in  7*DIGITS  segment patterns; digit k is `[7k+6:7k]`, active-high logical value.
- `blank`  in  DIGITS  1 = digit k dark for its slot.
- `brightness`  in  BRIGHT_BITS  duty setting; 0 = dark, all-ones = full on.
- `segment`  out  7  registered segment bus.
- `digit_sel`  out  DIGITS  registered one-hot digit enable.
- `frame_start`  out  1  one-cycle pulse at the start of each digit-0 slot.

## Operation
- Internal state: `cnt` (CBITS), `idx` (digit index, 0..DIGITS-1), and latched copies `seg_l`, `blank_l`, `bright_l`.
- Reset (rst=0 at an edge; reset dominates everything):
  - cnt=0, idx=DIGITS-1, seg_l=0, blank_l=1, bright_l=0, frame_start=0.
  - Logical segment=0 and digit_sel=0. Physical value is all-ones when ACTIVE_LOW=1.
- Counting: if cnt < FREQ, then cnt ← cnt+1. Otherwise (wrap edge) cnt ← 0, and:
  - idx ← (idx == DIGITS-1) ? 0 : idx+1.
  - seg_l ← digits_in slice of the new idx; blank_l ← blank[new idx]; bright_l ← brightness.
  - Inputs are sampled only on wrap edges. Changes mid-slot have no effect until the next slot.
- PWM:
  - STEP = (FREQ+1) >> BRIGHT_BITS, a constant.
  - on_cycles = bright_l * STEP. The product is computed at CBITS+BRIGHT_BITS width with no truncation.
  - Digit is lit when blank_l=0 and either bright_l is all-ones, or cnt < on_cycles.
- Outputs (logical, before polarity):
  - When lit: digit_sel = one-hot(idx) and segment = seg_l.
  - When not lit: digit_sel = 0 and segment = 0.
- Polarity: the physical output is the logical value XOR {ACTIVE_LOW}. This applies to both `segment` and `digit_sel`, including reset values.
- frame_start = 1 for exactly the one cycle immediately following a wrap edge that set idx=0. Otherwise it is 0.
- Scan order after reset: digit 0, 1, …, DIGITS-1, 0, …

## Timing
- All outputs are registers updated on the same edge as cnt. The value after an edge is a function of the post-edge cnt, idx and latched state. No combinational input→output paths.
- Slot = FREQ+1 clocks; frame = DIGITS*(FREQ+1) clocks.
- First lit slot (digit 0) begins FREQ+1 edges after the last reset edge. All outputs stay dark until then.
- Latency: input sampled at a wrap edge → visible on outputs in the cycle after that edge (0 extra cycles).
- Within a slot, a digit that is lit but not full-on is lit for cycles cnt = 0..on_cycles-1, then dark until the wrap.
- Reset mid-slot: the next edge forces reset values regardless of cnt. Scanning restarts from digit 0 as above.
- Boundaries:
  - brightness=0 gives dark even if blank=0.
  - blank overrides brightness.
  - idx wraps DIGITS-1 → 0 and never exceeds DIGITS-1.
  - digit_sel is never more than one-hot in logical form.

## Test plan
- Bench parameters: DIGITS=3, FREQ=7, CBITS=3, BRIGHT_BITS=2, ACTIVE_LOW=0 (STEP=2).
1. Reset and first slot: hold rst=0 for 2 cycles, then release with brightness=3, digits_in={7'h06,7'h5B,7'h3F}, blank=0.
   - Outputs stay 0 for 8 cycles.
   - Then digit_sel=3'b001, segment=7'h3F for 8 cycles, with frame_start=1 in the first of them.
2. Scan order: continue scenario 1.
   - Slot 2 gives 3'b010/7'h5B; slot 3 gives 3'b100/7'h06; then digit_sel=3'b001 again.
   - frame_start fires every 24 cycles.
3. PWM: brightness=1.
   - Each slot lit for cnt 0–1 (2 cycles), then dark for 6 cycles.
   - brightness=0 gives digit_sel=0 throughout.
4. Blank and mid-slot input change:
   - blank=3'b010: slot 2 fully dark while slots 1 and 3 show normally.
   - Changing digits_in[6:0] mid-slot 1 leaves segment unchanged until the next digit-0 slot.
5. Reset mid-operation: assert rst=0 at cnt=4 of slot 2.
   - Next edge: all outputs 0 and frame_start=0.
   - After release, digit 0 appears after 8 cycles.
6. Polarity: rerun scenario 1 with ACTIVE_LOW=1.
   - During reset, segment=7'h7F and digit_sel=3'b111.
   - Slot 1 gives digit_sel=3'b110, segment=7'h40.
